// File: rtl/fpu_divider_if.sv
// Operand/result handshake bundle for the single-precision divider.
// master drives operands and result acceptance; slave is the divider.
interface fpu_divider_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output busy
    );
endinterface

// File: rtl/fpu_divider.sv
// Iterative IEEE 754 single-precision divider, one restoring step per cycle.
// Truncating, denormals flushed to zero, special operands resolved at accept.
module fpu_divider #(
    parameter logic [31:0] QNAN = 32'h7FC00000
) (
    input  logic          clk,
    input  logic          rst_n,
    fpu_divider_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM,
        DONE
    } state_t;

    state_t state;

    logic        in_ready_q;
    logic        out_valid_q;
    logic        busy_q;
    logic [31:0] result_q;

    logic [4:0]  count;
    logic [24:0] rem;
    logic [23:0] dvs;
    logic [24:0] q;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic        sign;

    // operand classification
    logic [7:0]  a_exp;
    logic [7:0]  b_exp;
    logic        a_nan;
    logic        b_nan;
    logic        a_inf;
    logic        b_inf;
    logic        a_zero;
    logic        b_zero;
    logic        op_sign;
    logic        special;
    logic [31:0] special_res;

    // restoring step
    logic        rem_ge;
    logic [24:0] rem_sub;
    logic [24:0] rem_next;

    // normalisation
    logic signed [9:0] e_raw;
    logic signed [9:0] e_n;
    logic [22:0]       frac_n;
    logic [31:0]       norm_res;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = result_q;

    // Classify incoming operands and resolve the special-case result.
    always_comb begin
        a_exp       = bus.a[30:23];
        b_exp       = bus.b[30:23];
        a_nan       = (a_exp == 8'hFF) && (bus.a[22:0] != 23'd0);
        b_nan       = (b_exp == 8'hFF) && (bus.b[22:0] != 23'd0);
        a_inf       = (a_exp == 8'hFF) && (bus.a[22:0] == 23'd0);
        b_inf       = (b_exp == 8'hFF) && (bus.b[22:0] == 23'd0);
        a_zero      = (a_exp == 8'h00);
        b_zero      = (b_exp == 8'h00);
        op_sign     = bus.a[31] ^ bus.b[31];
        special     = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        special_res = {op_sign, 31'd0};
        if (a_nan) begin
            special_res = bus.a;
        end else if (b_nan) begin
            special_res = bus.b;
        end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            special_res = QNAN;
        end else if (a_inf || b_zero) begin
            special_res = {op_sign, 8'hFF, 23'd0};
        end else begin
            special_res = {op_sign, 31'd0};
        end
    end

    // One restoring-division step on the current partial remainder.
    always_comb begin
        rem_ge   = (rem >= {1'b0, dvs});
        rem_sub  = rem_ge ? (rem - {1'b0, dvs}) : rem;
        rem_next = rem_sub << 1;
    end

    // Exponent adjust, normalisation and overflow/underflow clamping.
    always_comb begin
        e_raw  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
        e_n    = q[24] ? e_raw : (e_raw - 10'sd1);
        frac_n = q[24] ? q[23:1] : q[22:0];
        if (e_n >= 10'sd255) begin
            norm_res = {sign, 8'hFF, 23'd0};
        end else if (e_n <= 10'sd0) begin
            norm_res = {sign, 31'd0};
        end else begin
            norm_res = {sign, e_n[7:0], frac_n};
        end
    end

    // Control FSM with registered handshake outputs and datapath state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= 32'd0;
            count       <= 5'd0;
            rem         <= 25'd0;
            dvs         <= 24'd0;
            q           <= 25'd0;
            ea          <= 8'd0;
            eb          <= 8'd0;
            sign        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        sign       <= op_sign;
                        ea         <= a_exp;
                        eb         <= b_exp;
                        rem        <= {2'b01, bus.a[22:0]};
                        dvs        <= {1'b1, bus.b[22:0]};
                        q          <= 25'd0;
                        count      <= 5'd0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (special) begin
                            result_q    <= special_res;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem   <= rem_next;
                    q     <= {q[23:0], rem_ge};
                    count <= count + 5'd1;
                    if (count == 5'd24) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    result_q    <= norm_res;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/fpu_divider.md
FPU_DIVIDER -- requirements
Module: fpu_divider

Interface
REQ-001 Parameter QNAN, default 32'h7FC00000, canonical NaN result for invalid operations.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operands a/b presented.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  32  IEEE 754 single-precision dividend.
REQ-007 b  input  32  IEEE 754 single-precision divisor.
REQ-008 out_valid  output  1  result holds a completed quotient.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 result  output  32  registered IEEE 754 single-precision quotient a/b.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states SHALL be IDLE, DIV, NORM, DONE; in_ready SHALL be high only in IDLE.
REQ-013 Operands SHALL be accepted and registered on an edge with in_valid & in_ready; a/b are ignored at all other times.
REQ-014 Operand classes: exp=255 & frac!=0 NaN; exp=255 & frac=0 inf; exp=0 (any frac) zero; denormals flushed to zero.
REQ-015 Special cases, priority order: a NaN -> a; b NaN -> b; inf/inf or zero/zero -> QNAN; a inf -> inf; b zero -> inf; b inf -> zero; a zero -> zero.
REQ-016 Inf and zero results SHALL carry sign a[31]^b[31] with fraction 0.
REQ-017 Special case at accept: result loaded, IDLE->DONE on the accept edge; out_valid high from the next cycle.
REQ-018 Normal case: IDLE->DIV; remainder <= {1'b0,1,a[22:0]} (25 bits); divisor = {1,b[22:0]}; iteration counter <= 0.
REQ-019 Each DIV cycle is one restoring step: if rem >= divisor, quotient bit 1 and rem -= divisor, else bit 0; quotient shifts left by 1 with the new bit; rem <<= 1.
REQ-020 DIV SHALL last exactly 25 cycles, producing q[24:0] with q[24] weight 2^0; then DIV->NORM.
REQ-021 NORM: 10-bit signed e = ea - eb + 127; if q[24]=1, frac = q[23:1]; else frac = q[22:0] and e = e-1.
REQ-022 NORM: e >= 255 -> signed inf; e <= 0 -> signed zero; else {sign,e[7:0],frac}; rounding SHALL be truncation; NORM->DONE.
REQ-023 Normal-case latency: out_valid high exactly 27 cycles after the accept edge.
REQ-024 DONE: out_valid high, result stable; on out_valid & out_ready, DONE->IDLE and out_valid deasserts next cycle.
REQ-025 result SHALL hold its last value after handshake until the next completion overwrites it.
REQ-026 No new operands SHALL be accepted in the cycle a result is consumed (in_ready rises the cycle after).

Reset
REQ-027 rst_n low at an edge SHALL force IDLE, out_valid=0, busy=0, in_ready=1 (next cycle), result=0, counter=0, from any state including mid-DIV.
REQ-028 An operation interrupted by reset SHALL be discarded, with no result produced.

Verification
REQ-029 a=0x40C00000, b=0x40000000 -> result 0x40400000, out_valid exactly 27 cycles after accept.
REQ-030 a=0x3F800000, b=0x40400000 -> result 0x3EAAAAAA (truncated 1/3).
REQ-031 a=0x3F800000, b=0x00000000 -> 0x7F800000 one cycle after accept; a=0, b=0 -> 0x7FC00000.
REQ-032 a=0xBF800000, b=0x7F800000 -> 0x80000000; a=0x7F000000, b=0x00800000 -> 0x7F800000 (overflow).
REQ-033 out_ready held low 10 cycles after completion -> out_valid and result stable, in_ready low, in_valid pulses ignored; out_ready high -> IDLE next cycle.
REQ-034 rst_n low at DIV cycle 12 -> next cycle IDLE, out_valid 0, result 0; the following operation 6.0/2.0 completes correctly.
